i2c_reg_target: RTL and testbench
=================================

Name: i2c_reg_target

Overview:
- I2C target (responder): the far end of the I2C configuration link that dvi_ifc drives as initiator.
- Presents an 8-bit-addressed register space to the bus and performs single or burst writes and reads.
- Used as the DVI-transmitter register model in benches and as an on-board debug/config target.
- Runs entirely in the clk_100mhz_buf domain. SCL and SDA are oversampled; the block never drives SCL (no clock stretching).

Parameters:
- DEV_ADDR, 7'h76, 7-bit device address this target answers to.
- SYNC_STAGES, 2, synchronizer flops on scl_in/sda_in (min 2).
- FILT_LEN, 3, consecutive equal samples required to accept a level change (glitch filter).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- scl_in  in  1  raw SCL from pad.
- sda_in  in  1  raw SDA from pad.
- sda_oe  out  1  1 = pull SDA low (pad logic makes it 1'b0 when set, z otherwise).
- reg_addr  out  8  current register pointer.
- wr_en  out  1  one-cycle strobe; write wr_data to reg_addr.
- wr_data  out  8  write data, valid with wr_en.
- rd_en  out  1  one-cycle strobe; requests rd_data for reg_addr.
- rd_data  in  8  read data; must be valid the cycle after rd_en.
- busy  out  1  high from an address-matched START until STOP.

Behaviour:
- Reset: sda_oe=0, reg_addr=0, wr_en=0, wr_data=0, rd_en=0, busy=0, state=IDLE. Filtered SCL/SDA preset to 1.
- Input path: SYNC_STAGES flops, then a FILT_LEN glitch filter. Edge detect on the filtered signals (scl_rise, scl_fall).
- START: filtered SDA 1->0 while SCL=1. STOP: SDA 0->1 while SCL=1. Both are detected in any state and take priority over bit handling.
- Bits are sampled on scl_rise. sda_oe changes only on scl_fall (plus 1 clk), so SDA is never changed while SCL is high.
- States:
  - IDLE: wait for START -> ADDR.
  - ADDR: shift 8 bits, MSB first. On the 8th scl_fall: if addr[7:1]==DEV_ADDR go to ADDR_ACK and assert sda_oe; otherwise go to IDLE (NACK, bus released).
  - ADDR_ACK: on scl_fall release SDA. If R/W=0 -> REG. If R/W=1 -> pulse rd_en, then load the shift register from rd_data one clk later -> RDATA.
  - REG: 8 bits into reg_addr. ACK -> WDATA.
  - WDATA: 8 bits. On the 8th scl_rise latch wr_data. On the following scl_fall drive the ACK and pulse wr_en for one clk. After ACK, reg_addr increments (wraps 8'hFF -> 8'h00) -> WDATA.
  - RDATA: drive the shift register MSB first; each bit is presented on scl_fall. After 8 bits release SDA -> RACK.
  - RACK: sample the initiator's ACK on scl_rise. ACK(0): increment reg_addr, pulse rd_en, reload -> RDATA. NACK(1): -> IDLE, SDA released.
- Repeated START in any non-IDLE state: go to ADDR, release SDA, keep reg_addr. This supports write-pointer-then-read.
- STOP in any state: go to IDLE, sda_oe=0, busy=0. A partially received WDATA byte is discarded (no wr_en).
- A read directly after an address phase uses the current reg_addr.
- rst asserted mid-transfer: outputs return to reset values next clk and SDA is released immediately.
- Throughput constraint: the SCL high and low phases must each be at least SYNC_STAGES+FILT_LEN+2 clk. Faster SCL is unsupported.

Decomposition:
- Shared package i2c_pkg: state encoding, I2C_ACK=1'b0, I2C_NACK=1'b1, default CH7301 address 7'h76.
- One sub-module, i2c_line_filter: synchronizer, glitch filter and edge/START/STOP detect. Instantiated once per line, with START/STOP derived in the parent.
- Target size: 250 RTL lines total.

Test Plan:
- Write 2 bytes: START, 0xEC, reg 0x49, 0xC0, 0x09, STOP -> ACK on all 4 bytes; wr_en pulses with (0x49,0xC0) then (0x4A,0x09); busy falls at STOP.
- Wrong address: START, 0xA0 -> sda_oe stays 0 for all 9 clocks; no strobes; state IDLE.
- Pointer then read burst: START, 0xEC, 0x21, rSTART, 0xED, model returns 0x55/0xAA; initiator ACK then NACK -> SDA bits read 0x55, 0xAA; rd_en pulses at reg 0x21 and 0x22; SDA released after NACK.
- Pointer wrap: write to reg 0xFF with 2 data bytes -> writes land at 0xFF then 0x00.
- STOP mid-byte after 5 data bits -> no wr_en, sda_oe=0, IDLE; a following valid transaction succeeds.
- Glitch and reset: a 1-clk SDA low pulse while SCL is high -> no START detected. rst asserted during RDATA while driving a 0 -> sda_oe=0 next clk and all outputs at reset values.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register target: bus constants and FSM state encoding.
package i2c_pkg;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  // Default 7-bit address of the CH7301 DVI transmitter.
  localparam logic [6:0] CH7301_ADDR = 7'h76;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BIT_CNT_W = 4;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RD_WAIT,
    ST_RD_FETCH,
    ST_RDATA,
    ST_RACK,
    ST_RACK_HOLD
  } i2c_state_e;

endpackage

// File: rtl/i2c_line_filter.sv
// One I2C line: synchronizer, glitch filter and registered rise/fall pulses of the
// filtered level.
module i2c_line_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   samp;

  assign samp = sync_q[SYNC_STAGES-1];

  // A new level is accepted only after FILT_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      cnt_q  <= '0;
      level  <= 1'b1;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      rise   <= 1'b0;
      fall   <= 1'b0;
      if (samp == level) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(FILT_LEN - 1)) begin
        level <= samp;
        cnt_q <= '0;
        rise  <= samp;
        fall  <= ~samp;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_reg_target.sv
// I2C target exposing an 8-bit-addressed register space with burst write/read and
// auto-incrementing register pointer. SCL is never driven.
module i2c_reg_target
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR    = CH7301_ADDR,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic       wr_en,
  output logic [7:0] wr_data,
  output logic       rd_en,
  input  logic [7:0] rd_data,
  output logic       busy
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(BYTE_W);
  localparam logic [BIT_CNT_W-1:0] PREV_BIT = BIT_CNT_W'(BYTE_W - 1);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_c, stop_c, byte_done;

  i2c_state_e           state_q, state_d;
  logic [7:0]           shift_q, shift_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                 rw_q, rw_d;
  logic                 sda_oe_d, wr_en_d, rd_en_d, busy_d;
  logic [7:0]           reg_addr_d, wr_data_d;

  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk   (clk),
    .rst   (rst),
    .raw   (scl_in),
    .level (scl_lvl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk   (clk),
    .rst   (rst),
    .raw   (sda_in),
    .level (sda_lvl),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  // Both lines see the same pipeline delay, so SDA edges line up with the SCL level.
  assign start_c   = sda_fall & scl_lvl;
  assign stop_c    = sda_rise & scl_lvl;
  assign byte_done = (bit_cnt_q == LAST_BIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      rw_q      <= 1'b0;
      sda_oe    <= 1'b0;
      reg_addr  <= '0;
      wr_en     <= 1'b0;
      wr_data   <= '0;
      rd_en     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      rw_q      <= rw_d;
      sda_oe    <= sda_oe_d;
      reg_addr  <= reg_addr_d;
      wr_en     <= wr_en_d;
      wr_data   <= wr_data_d;
      rd_en     <= rd_en_d;
      busy      <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe;
    reg_addr_d = reg_addr;
    wr_data_d  = wr_data;
    busy_d     = busy;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;

    if (stop_c) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_c) begin
      // Repeated START keeps reg_addr so a pointer write can be followed by a read.
      state_d   = ST_ADDR;
      sda_oe_d  = 1'b0;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;

        ST_ADDR: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_lvl};
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end else if (scl_fall && byte_done) begin
            bit_cnt_d = '0;
            if (shift_q[7:1] == DEV_ADDR) begin
              sda_oe_d = 1'b1;
              rw_d     = shift_q[0];
              busy_d   = 1'b1;
              state_d  = ST_ADDR_ACK;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end

        ST_ADDR_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            if (rw_q) begin
              rd_en_d = 1'b1;
              state_d = ST_RD_WAIT;
            end else begin
              state_d = ST_REG;
            end
          end
        end

        ST_REG: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_lvl};
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end else if (scl_fall && byte_done) begin
            reg_addr_d = shift_q;
            sda_oe_d   = 1'b1;
            bit_cnt_d  = '0;
            state_d    = ST_REG_ACK;
          end
        end

        ST_REG_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            state_d   = ST_WDATA;
          end
        end

        // Data is committed only at the ACK, so a STOP mid-byte writes nothing.
        ST_WDATA: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_lvl};
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            if (bit_cnt_q == PREV_BIT) begin
              wr_data_d = {shift_q[6:0], sda_lvl};
            end
          end else if (scl_fall && byte_done) begin
            sda_oe_d  = 1'b1;
            wr_en_d   = 1'b1;
            bit_cnt_d = '0;
            state_d   = ST_WDATA_ACK;
          end
        end

        ST_WDATA_ACK: begin
          if (scl_fall) begin
            sda_oe_d   = 1'b0;
            reg_addr_d = reg_addr + 8'd1;
            bit_cnt_d  = '0;
            state_d    = ST_WDATA;
          end
        end

        // rd_data is valid the cycle after rd_en; capture it one cycle later still.
        ST_RD_WAIT: state_d = ST_RD_FETCH;

        ST_RD_FETCH: begin
          shift_d   = rd_data;
          sda_oe_d  = ~rd_data[7];
          bit_cnt_d = '0;
          state_d   = ST_RDATA;
        end

        ST_RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end else if (scl_fall) begin
            if (byte_done) begin
              sda_oe_d = 1'b0;
              state_d  = ST_RACK;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end

        ST_RACK: begin
          if (scl_rise) begin
            state_d = (sda_lvl == I2C_ACK) ? ST_RACK_HOLD : ST_IDLE;
          end
        end

        // Next byte is fetched only once SCL is low again.
        ST_RACK_HOLD: begin
          if (scl_fall) begin
            reg_addr_d = reg_addr + 8'd1;
            rd_en_d    = 1'b1;
            state_d    = ST_RD_WAIT;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_reg_target.sv
// Bench for i2c_reg_target: bus-level initiator, register-file responder and a
// transaction-level model of pointer and memory contents.
module tb_i2c_reg_target;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       scl_in, sda_in, sda_oe, wr_en, rd_en, busy;
  logic [7:0] reg_addr, wr_data;
  logic [7:0] rd_data = '0;

  assign scl_in = m_scl;
  assign sda_in = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  i2c_reg_target dut (
    .clk      (clk),
    .rst      (rst),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .sda_oe   (sda_oe),
    .reg_addr (reg_addr),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .busy     (busy)
  );

  // Device-side register file answering the strobes.
  logic [7:0] dev_mem  [256];
  logic [7:0] seed_mem [256];
  logic       mem_load = 1'b0;

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) dev_mem[i] <= seed_mem[i];
    end else if (!rst && wr_en) begin
      dev_mem[reg_addr] <= wr_data;
    end
    if (!rst && rd_en) rd_data <= dev_mem[reg_addr];
  end

  logic [15:0] wr_log[$];
  logic [7:0]  rd_log[$];
  int          oe_cnt = 0;
  int          viol_cnt = 0;
  logic        prev_scl = 1'b1;
  logic        prev_oe = 1'b0;

  always @(posedge clk) begin
    if (!rst && wr_en) wr_log.push_back({reg_addr, wr_data});
    if (!rst && rd_en) rd_log.push_back(reg_addr);
    if (sda_oe) oe_cnt <= oe_cnt + 1;
    if (m_scl && prev_scl && (sda_oe !== prev_oe)) viol_cnt <= viol_cnt + 1;
    prev_scl <= m_scl;
    prev_oe  <= sda_oe;
  end

  // Reference model state
  logic [7:0]  exp_mem [256];
  logic [7:0]  ptr;
  logic [15:0] exp_wr[$];
  logic [7:0]  exp_rd[$];
  logic [7:0]  wbuf [8];
  int          wr_idx = 0;
  int          rd_idx = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_cycle(input logic b, output logic s);
    m_sda = b;
    clks(Q);
    m_scl = 1'b1;
    clks(Q);
    s = sda_in;
    clks(Q);
    m_scl = 1'b0;
    clks(Q);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1;
    clks(Q);
    m_scl = 1'b1;
    clks(Q);
    m_sda = 1'b0;
    clks(Q);
    m_scl = 1'b0;
    clks(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;
    clks(Q);
    m_scl = 1'b1;
    clks(Q);
    m_sda = 1'b1;
    clks(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], s);
    bit_cycle(1'b1, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, s);
      d[i] = s;
    end
    bit_cycle(nack, s);
  endtask

  task automatic check_logs(input string tag);
    check({tag, "_wr_count"}, 32'(wr_log.size() - wr_idx), 32'(exp_wr.size()));
    foreach (exp_wr[i])
      if (wr_idx + i < wr_log.size()) check({tag, "_wr"}, 32'(wr_log[wr_idx + i]), 32'(exp_wr[i]));
    wr_idx = wr_log.size();
    exp_wr.delete();
    check({tag, "_rd_count"}, 32'(rd_log.size() - rd_idx), 32'(exp_rd.size()));
    foreach (exp_rd[i])
      if (rd_idx + i < rd_log.size()) check({tag, "_rd_addr"}, 32'(rd_log[rd_idx + i]), 32'(exp_rd[i]));
    rd_idx = rd_log.size();
    exp_rd.delete();
    check({tag, "_ptr"}, 32'(reg_addr), 32'(ptr));
  endtask

  task automatic finish_txn(input string tag);
    i2c_stop();
    clks(4);
    check({tag, "_busy_end"}, 32'(busy), 0);
    check({tag, "_oe_end"}, 32'(sda_oe), 0);
    check_logs(tag);
  endtask

  // Write n bytes from wbuf starting at register p.
  task automatic do_write(input logic [7:0] p, input int n, input string tag);
    logic a;
    i2c_start();
    send_byte(8'hEC, a);
    check({tag, "_ack_dev"}, 32'(a), 0);
    send_byte(p, a);
    check({tag, "_ack_reg"}, 32'(a), 0);
    for (int i = 0; i < n; i++) begin
      send_byte(wbuf[i], a);
      check({tag, "_ack_data"}, 32'(a), 0);
      exp_wr.push_back({8'(p + i), wbuf[i]});
      exp_mem[8'(p + i)] = wbuf[i];
    end
    check({tag, "_busy"}, 32'(busy), 1);
    ptr = 8'(p + n);
    finish_txn(tag);
  endtask

  // Read n bytes, optionally setting the pointer first; last byte is NACKed.
  task automatic do_read(input logic set_ptr, input logic [7:0] p, input int n, input string tag);
    logic a;
    logic [7:0] d;
    i2c_start();
    if (set_ptr) begin
      send_byte(8'hEC, a);
      check({tag, "_ack_dev_w"}, 32'(a), 0);
      send_byte(p, a);
      check({tag, "_ack_reg"}, 32'(a), 0);
      ptr = p;
      i2c_start();
    end
    send_byte(8'hED, a);
    check({tag, "_ack_dev_r"}, 32'(a), 0);
    for (int i = 0; i < n; i++) begin
      read_byte(i == n - 1, d);
      check({tag, "_rd_data"}, 32'(d), 32'(exp_mem[8'(ptr + i)]));
      exp_rd.push_back(8'(ptr + i));
    end
    check({tag, "_oe_after_nack"}, 32'(sda_oe), 0);
    ptr = 8'(ptr + n - 1);
    finish_txn(tag);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic       a;
    logic [7:0] p;
    int         kind, n, base, k;
    logic       s;

    for (int i = 0; i < 256; i++) seed_mem[i] = 8'($urandom);
    seed_mem[8'h21] = 8'h55;
    seed_mem[8'h22] = 8'hAA;
    seed_mem[8'h30] = 8'h12;
    for (int i = 0; i < 256; i++) exp_mem[i] = seed_mem[i];
    ptr = 8'h00;

    mem_load = 1'b1;
    rst = 1'b1;
    clks(5);
    mem_load = 1'b0;
    check("reset_sda_oe", 32'(sda_oe), 0);
    check("reset_reg_addr", 32'(reg_addr), 0);
    check("reset_wr_en", 32'(wr_en), 0);
    check("reset_wr_data", 32'(wr_data), 0);
    check("reset_rd_en", 32'(rd_en), 0);
    check("reset_busy", 32'(busy), 0);
    rst = 1'b0;
    clks(10);

    // Two-byte write burst
    wbuf[0] = 8'hC0;
    wbuf[1] = 8'h09;
    do_write(8'h49, 2, "wr2");

    // Address not ours: no ACK, no strobes
    base = oe_cnt;
    i2c_start();
    send_byte(8'hA0, a);
    check("badaddr_nack", 32'(a), 1);
    check("badaddr_oe_cycles", 32'(oe_cnt - base), 0);
    finish_txn("badaddr");

    // Pointer write then repeated-START read burst
    do_read(1'b1, 8'h21, 2, "rdburst");

    // Pointer wrap
    wbuf[0] = 8'($urandom);
    wbuf[1] = 8'($urandom);
    do_write(8'hFF, 2, "wrap");

    // STOP after 5 data bits discards the byte
    i2c_start();
    send_byte(8'hEC, a);
    check("stopmid_ack_dev", 32'(a), 0);
    send_byte(8'h10, a);
    check("stopmid_ack_reg", 32'(a), 0);
    ptr = 8'h10;
    for (int i = 0; i < 5; i++) bit_cycle(1'(i % 2), s);
    finish_txn("stopmid");
    wbuf[0] = 8'($urandom);
    do_write(8'h11, 1, "after_stopmid");

    // 1-clk SDA glitch with SCL high must not look like a START
    @(negedge clk);
    m_sda = 1'b0;
    @(negedge clk);
    m_sda = 1'b1;
    clks(10);
    check("glitch_busy", 32'(busy), 0);
    base = oe_cnt;
    m_scl = 1'b0;
    clks(Q);
    send_byte(8'hEC, a);
    check("glitch_no_ack", 32'(a), 1);
    check("glitch_oe_cycles", 32'(oe_cnt - base), 0);
    finish_txn("glitch");

    // Reset while driving a 0 during a read
    i2c_start();
    send_byte(8'hEC, a);
    send_byte(8'h30, a);
    i2c_start();
    send_byte(8'hED, a);
    check("rstmid_ack_dev", 32'(a), 0);
    k = 0;
    while (!sda_oe && k < 200) begin
      clks(1);
      k++;
    end
    check("rstmid_oe_driven", 32'(sda_oe), 1);
    rst = 1'b1;
    clks(1);
    check("rstmid_sda_oe", 32'(sda_oe), 0);
    check("rstmid_busy", 32'(busy), 0);
    check("rstmid_reg_addr", 32'(reg_addr), 0);
    check("rstmid_rd_en", 32'(rd_en), 0);
    check("rstmid_wr_data", 32'(wr_data), 0);
    m_sda = 1'b1;
    clks(2);
    m_scl = 1'b1;
    clks(4);
    rst = 1'b0;
    clks(10);
    exp_rd.push_back(8'h30);
    ptr = 8'h00;
    check_logs("rstmid");

    // Randomized transactions against the model
    for (int it = 0; it < 10; it++) begin
      kind = int'($urandom_range(0, 2));
      n = int'($urandom_range(1, 4));
      p = 8'($urandom);
      if (kind == 0) begin
        for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
        do_write(p, n, "rnd_wr");
      end else if (kind == 1) begin
        do_read(1'b1, p, n, "rnd_rd_ptr");
      end else begin
        do_read(1'b0, 8'h00, n, "rnd_rd_cur");
      end
    end

    check("oe_stable_while_scl_high", 32'(viol_cnt), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
